spi_frame_arbiter: RTL

Shares one byte-wide SPI master engine between `NREQ` requesters, each owning a separate chip-select/LOAD line. It issues 16-bit frames (address byte, then data byte), as used by MAX7219-class peripherals. It sits between the engine (start/busy/data handshake) and display/peripheral controllers, and replaces per-client copies of the engine. Arbitration is round-robin; frames are atomic.

---
 rtl/spi_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/spi_frame_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: state encoding and sizing shared by the SPI frame arbiter
package spi_arb_pkg;
    typedef enum logic [2:0] {
        IDLE, SETUP, START_HI, WAIT_HI, START_LO, WAIT_LO, HOLD, GAP
    } spi_arb_state_t;
    localparam int SPI_ARB_BYTES   = 2;
    localparam int SPI_ARB_BYTE_W  = 8;
    localparam int SPI_ARB_FRAME_W = SPI_ARB_BYTES * SPI_ARB_BYTE_W;
    localparam int SPI_ARB_CNT_W   = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] w_cur;
    logic             w_found;
    // walk ptr+1, ptr+2, ... with wraparound at N; first active requester wins
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cur   = ptr;
        for (int k = 0; k < N; k++) begin
            w_cur = (w_cur == IDX_W'(N - 1)) ? '0 : w_cur + 1'b1;
            if (!w_found && req[w_cur]) begin
                w_found      = 1'b1;
                grant[w_cur] = 1'b1;
                idx          = w_cur;
            end
        end
    end
endmodule

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: shares one byte-wide SPI engine between requesters, sending atomic 16-bit frames
module spi_frame_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*SPI_ARB_FRAME_W-1:0] frame,
    output logic [NREQ-1:0]                 done,
    output logic [SPI_ARB_FRAME_W-1:0]      rx_data,
    output logic [NREQ-1:0]                 cs_n,
    output logic                            spi_start,
    output logic [SPI_ARB_BYTE_W-1:0]       spi_data,
    input  logic                            spi_busy,
    input  logic [SPI_ARB_BYTE_W-1:0]       spi_rx
);
    localparam int IDX_W = $clog2(NREQ);
    localparam logic [SPI_ARB_CNT_W-1:0] SETUP_LAST = SPI_ARB_CNT_W'(CS_SETUP - 1);
    localparam logic [SPI_ARB_CNT_W-1:0] HOLD_LAST  = SPI_ARB_CNT_W'(CS_HOLD - 1);
    localparam logic [SPI_ARB_CNT_W-1:0] GAP_LAST   = SPI_ARB_CNT_W'(CS_GAP - 1);

    spi_arb_state_t             r_state;
    logic [SPI_ARB_CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]           r_ptr;
    logic [NREQ-1:0]            r_gnt;
    logic [SPI_ARB_FRAME_W-1:0] r_frame;
    logic [SPI_ARB_FRAME_W-1:0] r_stage;
    logic [NREQ-1:0]            w_grant;
    logic [IDX_W-1:0]           w_idx;
    logic [SPI_ARB_FRAME_W-1:0] w_frame;
    logic                       w_timed;
    logic                       w_cnt_done;

    rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    // frame of the requester the arbiter is currently picking
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_grant[i]) w_frame = frame[SPI_ARB_FRAME_W*i +: SPI_ARB_FRAME_W];
    end

    assign w_timed    = (r_state == SETUP) || (r_state == HOLD) || (r_state == GAP);
    assign w_cnt_done = r_cnt == ((r_state == SETUP) ? SETUP_LAST : (r_state == HOLD) ? HOLD_LAST : GAP_LAST);

    // timing counter: runs only in the timed states and clears at each terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (w_timed && !w_cnt_done) ? r_cnt + 1'b1 : '0;
    end

    // frame sequencer; busy is ignored while our own start strobe is still visible to the engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= IDX_W'(NREQ - 1);
            r_gnt     <= '0;
            r_frame   <= '0;
            r_stage   <= '0;
            cs_n      <= '1;
            done      <= '0;
            rx_data   <= '0;
            spi_start <= 1'b0;
            spi_data  <= '0;
        end else begin
            spi_start <= 1'b0;
            done      <= '0;
            case (r_state)
                IDLE: if (|req && !spi_busy) begin
                    r_ptr   <= w_idx;
                    r_gnt   <= w_grant;
                    r_frame <= w_frame;
                    cs_n    <= ~w_grant;
                    r_state <= SETUP;
                end
                SETUP: if (w_cnt_done) r_state <= START_HI;
                START_HI: begin
                    spi_start <= 1'b1;
                    spi_data  <= r_frame[15:8];
                    r_state   <= WAIT_HI;
                end
                WAIT_HI: if (!spi_start && !spi_busy) begin
                    r_stage[15:8] <= spi_rx;
                    r_state       <= START_LO;
                end
                START_LO: begin
                    spi_start <= 1'b1;
                    spi_data  <= r_frame[7:0];
                    r_state   <= WAIT_LO;
                end
                WAIT_LO: if (!spi_start && !spi_busy) begin
                    r_stage[7:0] <= spi_rx;
                    r_state      <= HOLD;
                end
                HOLD: if (w_cnt_done) begin
                    cs_n    <= '1;
                    done    <= r_gnt;
                    rx_data <= r_stage;
                    r_state <= GAP;
                end
                GAP: if (w_cnt_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
